tilemap_engine: RTL and testbench

//  Parametrised tile-map background renderer for the VGA pipeline. Replaces the fixed 16x16 wall/road background.

---
 rtl/tilemap_pkg.sv | 32 +++
 rtl/tilemap_engine_ram.sv | 27 ++
 rtl/tilemap_engine.sv | 188 ++++++++++++++++++
 tb/tb_tilemap_engine.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tilemap_pkg.sv
// Shared types, atlas layout and default-map rule for the tile-map background renderer.
package tilemap_pkg;

   typedef enum logic [1:0] {
      ROAD    = 2'd0,
      BRICK   = 2'd1,
      STEEL   = 2'd2,
      CRACKED = 2'd3
   } tile_t;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      READ,
      WRITE,
      ACK
   } fsm_state_t;

   // 2x2 atlas in tile units: ROAD/BRICK on the top row, STEEL/CRACKED below
   localparam int unsigned ATLAS_COL [4] = '{0, 1, 0, 1};
   localparam int unsigned ATLAS_ROW [4] = '{0, 0, 1, 1};

   function automatic tile_t default_tile(input int unsigned col, input int unsigned row,
                                          input int unsigned map_w, input int unsigned map_h);
      if (col == 0 || row == 0 || col == map_w - 1 || row == map_h - 1)
         return STEEL;
      if ((col % 2 == 0) && (row % 2 == 0))
         return BRICK;
      return ROAD;
   endfunction

endpackage

// File: rtl/tilemap_engine_ram.sv
// Tile map storage: 2-bit cells, port A video read, port B read/write, both read-first.
module tile_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned AW    = 8
) (
   input  logic          clk,
   input  logic [AW-1:0] addr_a,
   output logic [1:0]    q_a,
   input  logic [AW-1:0] addr_b,
   input  logic          we_b,
   input  logic [1:0]    d_b,
   output logic [1:0]    q_b
);

   logic [1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      q_a <= mem[addr_a];
   end

   always_ff @(posedge clk) begin
      if (we_b)
         mem[addr_b] <= d_b;
      q_b <= mem[addr_b];
   end

endmodule

// File: rtl/tilemap_engine.sv
// Tile-map background renderer with runtime-destructible bricks.
// Define TILEMAP_DAMAGE_EN to make bricks crack on the first hit and vanish on the second.
module tilemap_engine
   import tilemap_pkg::*;
#(
   parameter int unsigned TILE_W = 32,
   parameter int unsigned TILE_H = 32,
   parameter int unsigned MAP_W  = 16,
   parameter int unsigned MAP_H  = 16,
   parameter logic [11:0] TRANSP = 12'h00f
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     video_on,
   input  logic [9:0]               x,
   input  logic [9:0]               y,
   output logic [9:0]               rom_x,
   output logic [9:0]               rom_y,
   input  logic [11:0]              rom_data,
   output logic                     pixel_on,
   output logic [11:0]              color,
   input  logic                     hit_valid,
   input  logic [$clog2(MAP_W)-1:0] hit_col,
   input  logic [$clog2(MAP_H)-1:0] hit_row,
   output logic                     hit_ready,
   output logic                     hit_destroyed,
   output logic                     init_done
);

   localparam int unsigned TWB   = $clog2(TILE_W);
   localparam int unsigned THB   = $clog2(TILE_H);
   localparam int unsigned CW    = $clog2(MAP_W);
   localparam int unsigned RW    = $clog2(MAP_H);
   localparam int unsigned CELLS = MAP_W * MAP_H;
   localparam int unsigned AW    = $clog2(CELLS);

   logic [9:0]     x0, y0;
   logic           v0, v1, v2, v3, m1, m2, m3;
   logic           inmap0, pix_hit;
   logic [TWB-1:0] xl1;
   logic [THB-1:0] yl1;
   logic [AW-1:0]  addr_a, addr_b, lat_addr;
   logic [1:0]     q_a, q_b;
   logic           we_b;
   tile_t          d_b;

   fsm_state_t     state, state_nx;
   logic [CW-1:0]  init_col;
   logic [RW-1:0]  init_row;
   logic [CW:0]    lat_col;
   logic [RW:0]    lat_row;
   logic           lat_in_range, init_last, destroy_nx, destroyed_q, init_done_q;

   tile_ram #(.DEPTH(CELLS), .AW(AW)) u_ram (
      .clk    (clk),
      .addr_a (addr_a),
      .q_a    (q_a),
      .addr_b (addr_b),
      .we_b   (we_b),
      .d_b    (d_b),
      .q_b    (q_b)
   );

   always_comb begin
      inmap0  = (32'(x0) < MAP_W * TILE_W) && (32'(y0) < MAP_H * TILE_H);
      addr_a  = inmap0 ? AW'(32'(y0 >> THB) * MAP_W + 32'(x0 >> TWB)) : '0;
      pix_hit = v3 && m3 && (rom_data != TRANSP);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x0 <= '0; y0 <= '0; v0 <= '0;
         v1 <= '0; m1 <= '0; xl1 <= '0; yl1 <= '0;
         v2 <= '0; m2 <= '0; v3 <= '0; m3 <= '0;
         rom_x <= '0; rom_y <= '0; pixel_on <= '0; color <= '0;
      end else begin
         x0  <= x;
         y0  <= y;
         v0  <= video_on;
         v1  <= v0;
         m1  <= inmap0;
         xl1 <= x0[TWB-1:0];
         yl1 <= y0[THB-1:0];
         v2  <= v1;
         m2  <= m1;
         rom_x <= m1 ? 10'(ATLAS_COL[q_a] * TILE_W + 32'(xl1)) : '0;
         rom_y <= m1 ? 10'(ATLAS_ROW[q_a] * TILE_H + 32'(yl1)) : '0;
         v3  <= v2;
         m3  <= m2;
         pixel_on <= pix_hit;
         color    <= pix_hit ? rom_data : '0;
      end
   end

   // Latched coordinates carry one extra bit so the range test stays meaningful
   always_comb begin
      lat_in_range = (32'(lat_col) < MAP_W) && (32'(lat_row) < MAP_H);
      lat_addr     = lat_in_range ? AW'(32'(lat_row) * MAP_W + 32'(lat_col)) : '0;
      init_last    = (32'(init_col) == MAP_W - 1) && (32'(init_row) == MAP_H - 1);
   end

   always_ff @(posedge clk) begin
      if (reset)
         state <= INIT;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      addr_b     = lat_addr;
      we_b       = 1'b0;
      d_b        = ROAD;
      destroy_nx = 1'b0;
      hit_ready  = 1'b0;
      case (state)
         INIT: begin
            addr_b = AW'(32'(init_row) * MAP_W + 32'(init_col));
            we_b   = 1'b1;
            d_b    = default_tile(32'(init_col), 32'(init_row), MAP_W, MAP_H);
            if (init_last)
               state_nx = IDLE;
         end
         IDLE: begin
            if (hit_valid && init_done_q)
               state_nx = READ;
         end
         READ: state_nx = WRITE;
         WRITE: begin
            case (tile_t'(q_b))
`ifdef TILEMAP_DAMAGE_EN
               BRICK:   d_b = CRACKED;
               CRACKED: begin
                  d_b        = ROAD;
                  destroy_nx = 1'b1;
               end
`else
               BRICK, CRACKED: begin
                  d_b        = ROAD;
                  destroy_nx = 1'b1;
               end
`endif
               default: d_b = tile_t'(q_b);
            endcase
            we_b       = lat_in_range && (d_b != tile_t'(q_b));
            destroy_nx = destroy_nx && lat_in_range;
            state_nx   = ACK;
         end
         ACK: begin
            hit_ready = 1'b1;
            state_nx  = IDLE;
         end
         default: state_nx = INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         init_col    <= '0;
         init_row    <= '0;
         lat_col     <= '0;
         lat_row     <= '0;
         destroyed_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         if (state == INIT) begin
            if (32'(init_col) == MAP_W - 1) begin
               init_col <= '0;
               init_row <= init_row + RW'(1);
            end else begin
               init_col <= init_col + CW'(1);
            end
            if (init_last)
               init_done_q <= 1'b1;
         end
         if (state == IDLE && hit_valid && init_done_q) begin
            lat_col <= {1'b0, hit_col};
            lat_row <= {1'b0, hit_row};
         end
         if (state == WRITE)
            destroyed_q <= destroy_nx;
      end
   end

   assign hit_destroyed = destroyed_q && (state == ACK);
   assign init_done     = init_done_q;

endmodule

// File: tb/tb_tilemap_engine.sv
// Self-checking bench for tilemap_engine: map/atlas model, ROM model, random pixels and hits.
module tb_tilemap_engine;

   logic        clk = 1'b0;
   logic        reset, video_on, pixel_on, hit_valid, hit_ready, hit_destroyed, init_done;
   logic [9:0]  x, y, rom_x, rom_y;
   logic [11:0] rom_data, color;
   logic [3:0]  hit_col, hit_row;

   always #5 clk = ~clk;

   tilemap_engine #(
      .TILE_W (32),
      .TILE_H (32),
      .MAP_W  (16),
      .MAP_H  (16),
      .TRANSP (12'h00f)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .video_on      (video_on),
      .x             (x),
      .y             (y),
      .rom_x         (rom_x),
      .rom_y         (rom_y),
      .rom_data      (rom_data),
      .pixel_on      (pixel_on),
      .color         (color),
      .hit_valid     (hit_valid),
      .hit_col       (hit_col),
      .hit_row       (hit_row),
      .hit_ready     (hit_ready),
      .hit_destroyed (hit_destroyed),
      .init_done     (init_done)
   );

   localparam int ACOL [4] = '{0, 1, 0, 1};
   localparam int AROW [4] = '{0, 0, 1, 1};

   int checks = 0;
   int passes = 0;
   int m [16][16];
   bit transp_mode = 1'b0;
   bit chk_en = 1'b0;
   int age = 0;
   int hx [5];
   int hy [5];
   bit hv [5];
   logic [11:0] c_rd;
   bit c_on;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp)
         passes++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [11:0] romf(input int rx, input int ry);
      int v;
      v = (rx * 37 + ry * 101) & 'hfff;
      if ((rx + ry) % 16 == 3) return 12'h00f;
      if (v == 'h00f) v = 'h0f0;
      return 12'(v);
   endfunction

   function automatic void model_reset();
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++)
            if (r == 0 || c == 0 || r == 15 || c == 15) m[r][c] = 2;
            else if (r % 2 == 0 && c % 2 == 0) m[r][c] = 1;
            else m[r][c] = 0;
   endfunction

   function automatic int exp_rx(input int xx, input int yy);
      if (xx >= 512 || yy >= 512) return 0;
      return ACOL[m[yy / 32][xx / 32]] * 32 + xx % 32;
   endfunction

   function automatic int exp_ry(input int xx, input int yy);
      if (xx >= 512 || yy >= 512) return 0;
      return AROW[m[yy / 32][xx / 32]] * 32 + yy % 32;
   endfunction

   always @(posedge clk)
      rom_data <= transp_mode ? 12'h00f : romf(int'(rom_x), int'(rom_y));

   always @(posedge clk) begin
      for (int i = 4; i > 0; i--) begin
         hx[i] <= hx[i - 1];
         hy[i] <= hy[i - 1];
         hv[i] <= hv[i - 1];
      end
      hx[0] <= int'(x);
      hy[0] <= int'(y);
      hv[0] <= video_on;
      age   <= chk_en ? ((age < 8) ? age + 1 : age) : 0;
   end

   always @(negedge clk) begin
      if (chk_en && age >= 3) begin
         chk("rom_x", int'(rom_x), exp_rx(hx[2], hy[2]));
         chk("rom_y", int'(rom_y), exp_ry(hx[2], hy[2]));
      end
      if (chk_en && age >= 5) begin
         c_rd = transp_mode ? 12'h00f : romf(exp_rx(hx[4], hy[4]), exp_ry(hx[4], hy[4]));
         c_on = hv[4] && hx[4] < 512 && hy[4] < 512 && c_rd != 12'h00f;
         chk("pixel_on", int'(pixel_on), int'(c_on));
         chk("color", int'(color), c_on ? int'(c_rd) : 0);
      end
   end

   task automatic probe(input int xx, input int yy, input int erx, input int ery,
                        input int eon, input int ecol);
      @(posedge clk); #1;
      x = 10'(xx); y = 10'(yy); video_on = 1'b1;
      @(posedge clk); #1;
      video_on = 1'b0; x = '0; y = '0;
      @(posedge clk);
      @(posedge clk); #1;
      chk("probe_rom_x", int'(rom_x), erx);
      chk("probe_rom_y", int'(rom_y), ery);
      @(posedge clk);
      @(posedge clk); #1;
      chk("probe_pixel_on", int'(pixel_on), eon);
      chk("probe_color", int'(color), ecol);
   endtask

   task automatic do_hit(input int c, input int r, output bit dest);
      int lat, code, exp_code;
      bit exp_dest;
      lat = 0;
      dest = 1'b0;
      code = m[r][c];
      exp_code = code;
      exp_dest = 1'b0;
`ifdef TILEMAP_DAMAGE_EN
      if (code == 1) exp_code = 3;
      else if (code == 3) begin exp_code = 0; exp_dest = 1'b1; end
`else
      if (code == 1 || code == 3) begin exp_code = 0; exp_dest = 1'b1; end
`endif
      @(posedge clk); #1;
      hit_valid = 1'b1; hit_col = 4'(c); hit_row = 4'(r);
      for (int n = 1; n <= 10 && lat == 0; n++) begin
         @(negedge clk);
         if (hit_ready) begin
            lat = n;
            dest = hit_destroyed;
         end
      end
      chk("hit_latency", lat, 4);
      if (lat != 0) chk("hit_destroyed", int'(dest), int'(exp_dest));
      @(posedge clk); #1;
      hit_valid = 1'b0;
      @(negedge clk);
      chk("hit_ready_single", int'(hit_ready), 0);
      m[r][c] = exp_code;
   endtask

   task automatic wait_init(input bit expect_no_ack);
      int cnt;
      cnt = 0;
      while (!init_done && cnt < 400) begin
         @(posedge clk); #1;
         cnt++;
         if (expect_no_ack) chk("no_ack_in_init", int'(hit_ready), 0);
         else begin
            chk("init_pixel_on", int'(pixel_on), 0);
            chk("init_color", int'(color), 0);
         end
      end
      chk("init_latency", cnt, 256);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      bit d;
      reset = 1'b1; video_on = 1'b0; x = '0; y = '0;
      hit_valid = 1'b0; hit_col = '0; hit_row = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rom_x", int'(rom_x), 0);
      chk("rst_rom_y", int'(rom_y), 0);
      chk("rst_pixel_on", int'(pixel_on), 0);
      chk("rst_color", int'(color), 0);
      chk("rst_hit_ready", int'(hit_ready), 0);
      chk("rst_hit_destroyed", int'(hit_destroyed), 0);
      chk("rst_init_done", int'(init_done), 0);
      reset = 1'b0;
      model_reset();
      wait_init(1'b0);

      probe(0, 0, 0, 32, 1, 'hca0);
      transp_mode = 1'b1;
      probe(0, 0, 0, 32, 0, 0);
      transp_mode = 1'b0;
      probe(600, 0, 0, 0, 0, 0);
      probe(100, 520, 0, 0, 0, 0);

      probe(70, 70, 38, 6, 1, 'h7dc);
      do_hit(2, 2, d);
`ifdef TILEMAP_DAMAGE_EN
      chk("hit22_literal", int'(d), 0);
      probe(70, 70, 38, 38, 1, 'h47c);
`else
      chk("hit22_literal", int'(d), 1);
      probe(70, 70, 6, 6, 1, 'h33c);
`endif
      do_hit(0, 0, d);
      chk("hit00_literal", int'(d), 0);
      probe(0, 0, 0, 32, 1, 'hca0);
      do_hit(4, 4, d);
`ifdef TILEMAP_DAMAGE_EN
      chk("hit44_first", int'(d), 0);
`else
      chk("hit44_first", int'(d), 1);
`endif
      do_hit(4, 4, d);
`ifdef TILEMAP_DAMAGE_EN
      chk("hit44_second", int'(d), 1);
`else
      chk("hit44_second", int'(d), 0);
`endif

      for (int blk = 0; blk < 8; blk++) begin
         chk_en = 1'b1;
         repeat (250) begin
            x = 10'($urandom_range(0, 639));
            y = 10'($urandom_range(0, 549));
            video_on = ($urandom_range(0, 9) != 0);
            @(posedge clk); #1;
         end
         chk_en = 1'b0;
         repeat (3) do_hit($urandom_range(0, 15), $urandom_range(0, 15), d);
         if (blk % 3 == 2) transp_mode = ~transp_mode;
      end
      transp_mode = 1'b0;
      video_on = 1'b0;

      // reset in the middle of a hit: the pending request must never be acknowledged
      @(posedge clk); #1;
      hit_valid = 1'b1; hit_col = 4'd6; hit_row = 4'd6;
      @(posedge clk);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midhit_ready", int'(hit_ready), 0);
      chk("midhit_init_done", int'(init_done), 0);
      chk("midhit_rom_x", int'(rom_x), 0);
      reset = 1'b0;
      repeat (100) begin
         @(posedge clk); #1;
         chk("midinit_no_ack", int'(hit_ready), 0);
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      wait_init(1'b1);
      hit_valid = 1'b0;
      repeat (4) begin
         @(negedge clk);
         chk("post_init_no_ack", int'(hit_ready), 0);
      end

      @(posedge clk); #1;
      chk_en = 1'b1;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) begin
            x = 10'(c * 32 + $urandom_range(0, 31));
            y = 10'(r * 32 + $urandom_range(0, 31));
            video_on = 1'b1;
            @(posedge clk); #1;
         end
      video_on = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      chk_en = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
